// File: rtl/regfile_writeback.sv
// ============================================================================
// regfile_writeback: merges ALU and load writebacks through a small FIFO into
// one register-file write per cycle, with a forwarding lookup for decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid,
  input  logic [ADDR_W-1:0]         a_reg,
  input  logic [DATA_W-1:0]         a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [ADDR_W-1:0]         b_reg,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      b_ready,
  input  logic                      hold,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  input  logic [ADDR_W-1:0]         chk_reg,
  output logic                      chk_hit,
  output logic [DATA_W-1:0]         chk_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] b_slot;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] count_next;
  logic             a_push;
  logic             b_push;
  logic             a_store;
  logic             b_store;
  logic             pop;

  // Readiness looks only at current occupancy; a same-cycle pop is not credited.
  assign space   = CNT_W'(DEPTH) - count;
  assign a_ready = (space != '0);
  assign b_ready = a_valid ? (space >= CNT_W'(2)) : (space != '0);

  assign a_push  = a_valid & a_ready;
  assign b_push  = b_valid & b_ready;
  assign a_store = a_push & (a_reg != '0);
  assign b_store = b_push & (b_reg != '0);
  assign b_slot  = wptr + PTR_W'(a_store);

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign regWrite = !empty && !hold;
  assign pop      = regWrite;

  assign write_reg  = empty ? '0 : reg_mem[rptr];
  assign write_data = empty ? '0 : data_mem[rptr];

  assign count_next = count + CNT_W'(a_store) + CNT_W'(b_store) - CNT_W'(pop);

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (a_store) begin
      reg_mem[wptr]  <= a_reg;
      data_mem[wptr] <= a_data;
    end
    if (b_store) begin
      reg_mem[b_slot]  <= b_reg;
      data_mem[b_slot] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (pop) rptr <= rptr + PTR_W'(1);
      wptr  <= wptr + PTR_W'(a_store) + PTR_W'(b_store);
      count <= count_next;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    chk_hit  = 1'b0;
    chk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (chk_reg != '0) && (reg_mem[idx] == chk_reg)) begin
        chk_hit  = 1'b1;
        chk_data = data_mem[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: scoreboard queue of accepted writes, popped
// and compared whenever the DUT should issue a register-file write.
`default_nettype none

module tb_regfile_writeback;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, b_valid, hold;
  logic [ADDR_W-1:0] a_reg, b_reg, chk_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, regWrite, chk_hit, full, empty;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data, chk_data;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
    .chk_reg(chk_reg), .chk_hit(chk_hit), .chk_data(chk_data),
    .count(count), .full(full), .empty(empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive after negedge, check against model, advance model at the edge.
  task automatic step(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                      input logic bv, input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd,
                      input logic h, input logic [ADDR_W-1:0] cr);
    int occ;
    logic ea, eb, ew, eh;
    logic [DATA_W-1:0] ed;
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    hold = h; chk_reg = cr;
    #1;
    occ = sb.size();
    ea  = (DEPTH - occ) >= 1;
    eb  = (DEPTH - occ) >= (av ? 2 : 1);
    ew  = (occ != 0) && !h;
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    check("count", count, occ);
    check("empty", empty, occ == 0);
    check("full", full, occ == DEPTH);
    check("regWrite", regWrite, ew);
    check("write_reg", write_reg, (occ != 0) ? sb[0].r : '0);
    check("write_data", write_data, (occ != 0) ? sb[0].d : '0);
    eh = 1'b0; ed = '0;
    if (cr != '0)
      foreach (sb[i]) if (sb[i].r == cr) begin eh = 1'b1; ed = sb[i].d; end
    check("chk_hit", chk_hit, eh);
    check("chk_data", chk_data, ed);
    if (ew) void'(sb.pop_front());
    if (av && ea && ar != '0) sb.push_back('{ar, ad});
    if (bv && eb && br != '0) sb.push_back('{br, bd});
    @(posedge clk);
  endtask

  task automatic idle(input logic h, input logic [ADDR_W-1:0] cr);
    step(1'b0, '0, '0, 1'b0, '0, '0, h, cr);
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0; chk_reg = 5'd3;
    #12;
    check("rst_regWrite", regWrite, 1'b0);
    check("rst_write_reg", write_reg, '0);
    check("rst_write_data", write_data, '0);
    check("rst_count", count, '0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_ready", b_ready, 1'b1);
    check("rst_chk_hit", chk_hit, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Single push, one-cycle latency, then empty again
    step(1'b1, 5'd8, 32'h11, 1'b0, '0, '0, 1'b0, 5'd8);
    idle(1'b0, 5'd8);
    idle(1'b0, 5'd8);

    // Same-cycle A/B to reg 9: A older, forward the youngest
    step(1'b1, 5'd9, 32'd5, 1'b1, 5'd9, 32'd7, 1'b0, 5'd9);
    idle(1'b0, 5'd9);
    idle(1'b0, 5'd9);
    idle(1'b0, 5'd9);

    // Fill under hold, count==3 with both valid, then full
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd2);
    step(1'b1, 5'd3, 32'hA3, 1'b0, '0, '0, 1'b1, 5'd3);
    step(1'b1, 5'd4, 32'hA4, 1'b1, 5'd5, 32'hB5, 1'b1, 5'd4);
    step(1'b1, 5'd6, 32'hA6, 1'b1, 5'd7, 32'hB7, 1'b1, 5'd1);
    // Full with a simultaneous pop: readies stay low this cycle
    step(1'b1, 5'd6, 32'hC6, 1'b1, 5'd7, 32'hC7, 1'b0, 5'd3);
    step(1'b1, 5'd10, 32'hCA, 1'b0, '0, '0, 1'b0, 5'd10);
    repeat (5) idle(1'b0, 5'd10);

    // A to reg 0 discarded, B takes its slot
    step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd2, 32'hAB, 1'b1, 5'd0);
    idle(1'b1, 5'd0);
    idle(1'b1, 5'd2);
    idle(1'b0, 5'd2);
    idle(1'b0, 5'd2);

    // Pointer wrap: alternating A/B stream with hold toggling
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0)
        step(1'b1, 5'(11 + i), 32'h100 + 32'(i), 1'b0, '0, '0, (i % 3) == 0, 5'(11 + i));
      else
        step(1'b0, '0, '0, 1'b1, 5'(11 + i), 32'h200 + 32'(i), (i % 3) == 0, 5'(10 + i));
    end
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
    for (int i = 0; i < 8; i++) idle(1'b0, 5'd1);

    // Async reset with three entries pending
    step(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1, 5'd20);
    step(1'b1, 5'd22, 32'h22, 1'b0, '0, '0, 1'b1, 5'd20);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0; chk_reg = 5'd21;
    #1;
    check("pre_rst_regWrite", regWrite, 1'b1);
    check("pre_rst_count", count, 3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_regWrite", regWrite, 1'b0);
    check("mid_rst_count", count, '0);
    check("mid_rst_chk_hit", chk_hit, 1'b0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    idle(1'b0, 5'd21);
    idle(1'b0, 5'd22);
    idle(1'b0, 5'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
